// File: rtl/calc_sequencer_if.sv
// Signal bundle for calc_sequencer: request/operand inputs, adder drive/return, result/status.
// With CALC_CHAIN_EN defined the bundle also carries the chain request.
interface calc_sequencer_if;
    logic       start;
    logic [2:0] op;
    logic [3:0] a_in;
    logic [3:0] b_in;
`ifdef CALC_CHAIN_EN
    logic       chain;
`endif
    logic [3:0] adder_x;
    logic [3:0] adder_y;
    logic       adder_cin;
    logic [3:0] adder_sum;
    logic [3:0] result;
    logic       ovf;
    logic       busy;
    logic       done;

`ifdef CALC_CHAIN_EN
    modport slave  (input  start, op, a_in, b_in, chain, adder_sum,
                    output adder_x, adder_y, adder_cin, result, ovf, busy, done);
    modport master (output start, op, a_in, b_in, chain, adder_sum,
                    input  adder_x, adder_y, adder_cin, result, ovf, busy, done);
`else
    modport slave  (input  start, op, a_in, b_in, adder_sum,
                    output adder_x, adder_y, adder_cin, result, ovf, busy, done);
    modport master (output start, op, a_in, b_in, adder_sum,
                    input  adder_x, adder_y, adder_cin, result, ovf, busy, done);
`endif
endinterface

// File: rtl/calc_sequencer.sv
// Sequencer for the shared 4-bit adder: capture, execute, done pulse.
// Optional CALC_CHAIN_EN: chain=1 with start reuses the current result as operand A.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for start; busy low
// S_CAPTURE | latching operands and opcode
// S_EXEC    | driving the adder; result/ovf register at the edge
// S_DONE    | one-cycle done pulse
module calc_sequencer (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    calc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EXEC, S_DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_ra;
    logic [3:0] r_rb;
    logic [2:0] r_rop;
    logic [3:0] r_result;
    logic       r_ovf;
`ifdef CALC_CHAIN_EN
    logic       r_chain;
`endif

    logic [3:0] w_x;
    logic [3:0] w_y;
    logic       w_cin;
    logic [3:0] w_abs_src;
    logic       w_ovf;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_EXEC;
            S_EXEC:    w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Opcode map: x00 add, 001 A-B, 101 B-A, 11x |A|, 01x |B|.
    always_comb begin
        w_x       = 4'd0;
        w_y       = 4'd0;
        w_cin     = 1'b0;
        w_abs_src = 4'd0;
        if (r_state == S_EXEC) begin
            if (r_rop[1:0] == 2'b00) begin
                w_x = r_ra;
                w_y = r_rb;
            end else if (r_rop == 3'b001) begin
                w_x   = r_ra;
                w_y   = ~r_rb;
                w_cin = 1'b1;
            end else if (r_rop == 3'b101) begin
                w_x   = r_rb;
                w_y   = ~r_ra;
                w_cin = 1'b1;
            end else begin
                w_abs_src = r_rop[2] ? r_ra : r_rb;
                if (w_abs_src[3]) begin
                    w_y   = ~w_abs_src;
                    w_cin = 1'b1;
                end else begin
                    w_x = w_abs_src;
                end
            end
        end
    end

    // |-8| lands here too: X=0, Y=0111, sum=1000.
    assign w_ovf = (w_x[3] == w_y[3]) & (bus.adder_sum[3] != w_x[3]);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ra     <= 4'd0;
            r_rb     <= 4'd0;
            r_rop    <= 3'd0;
            r_result <= 4'd0;
            r_ovf    <= 1'b0;
`ifdef CALC_CHAIN_EN
            r_chain  <= 1'b0;
`endif
        end else begin
`ifdef CALC_CHAIN_EN
            if (r_state == S_IDLE) r_chain <= bus.start & bus.chain;
`endif
            if (r_state == S_CAPTURE) begin
`ifdef CALC_CHAIN_EN
                r_ra <= r_chain ? r_result : bus.a_in;
`else
                r_ra <= bus.a_in;
`endif
                r_rb  <= bus.b_in;
                r_rop <= bus.op;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.adder_sum;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign bus.adder_x   = w_x;
    assign bus.adder_y   = w_y;
    assign bus.adder_cin = w_cin;
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed plan cases plus random operations
// checked against an integer-arithmetic reference model.
module tb_calc_sequencer;

    logic CLOCK_50;
    logic RESET_N;
    int   n_checks;
    int   n_fail;
    logic [3:0] m_result;
    logic       m_ovf;

    calc_sequencer_if bus ();

    calc_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus.slave)
    );

    assign bus.adder_sum = bus.adder_x + bus.adder_y + {3'b000, bus.adder_cin};

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Signed integer reference: result is the value mod 16, ovf when it leaves [-8,7].
    function automatic logic [4:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] opc);
        int sa, sb, v;
        sa = $signed(a);
        sb = $signed(b);
        if (opc[1:0] == 2'b00)      v = sa + sb;
        else if (opc == 3'b001)     v = sa - sb;
        else if (opc == 3'b101)     v = sb - sa;
        else if (opc[2:1] == 2'b11) v = (sa < 0) ? -sa : sa;
        else                        v = (sb < 0) ? -sb : sb;
        return {(v > 7 || v < -8), v[3:0]};
    endfunction

    task automatic set_chain(input logic ch);
`ifdef CALC_CHAIN_EN
        bus.chain = ch;
`else
        if (ch) $display("note: chain request ignored in this build");
`endif
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] opc, input logic ch);
        logic [3:0] src_a;
        logic [4:0] e;
        src_a = a;
`ifdef CALC_CHAIN_EN
        if (ch) src_a = m_result;
`endif
        e = ref_calc(src_a, b, opc);
        @(posedge CLOCK_50); #1;
        bus.a_in = a; bus.b_in = b; bus.op = opc; bus.start = 1'b1;
        set_chain(ch);
        @(posedge CLOCK_50); #1;
        bus.start = 1'b0;
        set_chain(1'($urandom_range(0, 1)));
        check_eq("busy_capture", bus.busy, 1);
        check_eq("done_capture", bus.done, 0);
        @(posedge CLOCK_50); #1;
        bus.a_in = 4'($urandom); bus.b_in = 4'($urandom); bus.op = 3'($urandom);
        check_eq("busy_exec", bus.busy, 1);
        check_eq("done_exec", bus.done, 0);
        check_eq("result_hold", bus.result, m_result);
        check_eq("ovf_hold", bus.ovf, m_ovf);
        @(posedge CLOCK_50); #1;
        check_eq("done_pulse", bus.done, 1);
        check_eq("busy_done", bus.busy, 1);
        check_eq("result", bus.result, e[3:0]);
        check_eq("ovf", bus.ovf, e[4]);
        m_result = e[3:0];
        m_ovf    = e[4];
        @(posedge CLOCK_50); #1;
        check_eq("done_low", bus.done, 0);
        check_eq("busy_idle", bus.busy, 0);
        set_chain(1'b0);
    endtask

    initial begin
        logic [4:0] e1, e2;
        int done_seen;
        n_checks = 0;
        n_fail   = 0;
        m_result = 4'd0;
        m_ovf    = 1'b0;
        RESET_N  = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a_in = 4'd0; bus.b_in = 4'd0;
        set_chain(1'b0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst_result", bus.result, 0);
        check_eq("rst_ovf", bus.ovf, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        RESET_N = 1'b1;

        do_op(4'b0011, 4'b0100, 3'b000, 1'b0);
        do_op(4'b0111, 4'b0001, 3'b000, 1'b0);
        do_op(4'b0010, 4'b0101, 3'b001, 1'b0);
        do_op(4'b0010, 4'b0101, 3'b101, 1'b0);
        do_op(4'b1000, 4'b0001, 3'b001, 1'b0);
        do_op(4'b1011, 4'b0000, 3'b110, 1'b0);
        do_op(4'b0000, 4'b0110, 3'b010, 1'b0);
        do_op(4'b1000, 4'b0000, 3'b111, 1'b0);
        do_op(4'b0000, 4'b1000, 3'b011, 1'b0);

`ifdef CALC_CHAIN_EN
        do_op(4'b0001, 4'b0010, 3'b000, 1'b0);
        do_op(4'b1111, 4'b0010, 3'b000, 1'b1);
        do_op(4'b1111, 4'b0011, 3'b000, 1'b1);
`endif

        // Back-to-back with start held high; operands change during EXEC.
        e1 = ref_calc(4'b0101, 4'b0001, 3'b001);
        e2 = ref_calc(4'b1110, 4'b0011, 3'b101);
        @(posedge CLOCK_50); #1;
        bus.a_in = 4'b0101; bus.b_in = 4'b0001; bus.op = 3'b001; bus.start = 1'b1;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        bus.a_in = 4'b1110; bus.b_in = 4'b0011; bus.op = 3'b101;
        @(posedge CLOCK_50); #1;
        check_eq("b2b_done1", bus.done, 1);
        check_eq("b2b_result1", bus.result, e1[3:0]);
        check_eq("b2b_ovf1", bus.ovf, e1[4]);
        @(posedge CLOCK_50); #1;
        check_eq("b2b_gap", bus.busy, 0);
        @(posedge CLOCK_50); #1;
        bus.start = 1'b0;
        check_eq("b2b_busy2", bus.busy, 1);
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        check_eq("b2b_done2", bus.done, 1);
        check_eq("b2b_result2", bus.result, e2[3:0]);
        check_eq("b2b_ovf2", bus.ovf, e2[4]);
        m_result = e2[3:0];
        m_ovf    = e2[4];
        @(posedge CLOCK_50); #1;
        check_eq("b2b_idle", bus.busy, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset during EXEC with a nonzero result already registered.
        do_op(4'b0011, 4'b0100, 3'b000, 1'b0);
        @(posedge CLOCK_50); #1;
        bus.a_in = 4'b0111; bus.b_in = 4'b0001; bus.op = 3'b000; bus.start = 1'b1;
        @(posedge CLOCK_50); #1;
        bus.start = 1'b0;
        @(posedge CLOCK_50); #1;
        check_eq("pre_rst_busy", bus.busy, 1);
        RESET_N = 1'b0;
        #1;
        check_eq("mid_rst_result", bus.result, 0);
        check_eq("mid_rst_ovf", bus.ovf, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_done", bus.done, 0);
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        m_result = 4'd0;
        m_ovf    = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLOCK_50); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check_eq("post_rst_quiet", done_seen, 0);
        check_eq("post_rst_result", bus.result, 0);

`ifdef CALC_CHAIN_EN
        do_op(4'b1010, 4'b0010, 3'b000, 1'b1);
`else
        do_op(4'b1010, 4'b0010, 3'b000, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Clocked controller that sequences the shared 4-bit adder datapath of the lab-4 calculator. It captures operands and a 3-bit opcode on a start request, drives the adder operands (X, Y, carry-in) for add, A−B, B−A, |A| and |B|, and registers the signed result plus an overflow flag. It finishes with a one-cycle done pulse. It sits between the switch/key input logic and the seven-segment display drivers.

## Interface
No parameters; all widths are fixed at 4-bit operands and a 3-bit opcode.
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  opcode. op[1:0]=00 → A+B. op=001 → A−B. op=101 → B−A. op[2:1]=11 → |A|. op[2:1]=01 → |B|.
- a_in, b_in  in  4 each  signed two's-complement operands.
- adder_x, adder_y  out  4 each  operands to the external combinational adder.
- adder_cin  out  1  carry-in to the adder.
- adder_sum  in  4  adder result, X+Y+cin mod 16.
- result  out  4  registered signed result.
- ovf  out  1  registered signed overflow.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/ovf update.

## Operation
States: IDLE, CAPTURE, EXEC, DONE.
- IDLE: if start=1, go to CAPTURE.
- CAPTURE: latch a_in, b_in and op into internal registers (ra, rb, rop). Go to EXEC.
- EXEC: drive the adder from the latched values. On the clock edge, register result←adder_sum and ovf←(X[3]==Y[3]) & (adder_sum[3]!=X[3]). Go to DONE.
- DONE: done=1 for exactly this cycle. Go to IDLE.
- Adder drive in EXEC:
  - add: X=ra, Y=rb, cin=0.
  - A−B: X=ra, Y=~rb, cin=1.
  - B−A: X=rb, Y=~ra, cin=1.
  - |A| with ra[3]=1: X=0, Y=~ra, cin=1. With ra[3]=0: X=ra, Y=0, cin=0.
  - |B|: same rule applied to rb.
- Outside EXEC: adder_x=0, adder_y=0, adder_cin=0.
- Overflow cases: ovf=1 for signed add/sub overflow and for |−8| (result=1000). Otherwise ovf=0.
- result and ovf hold their values until the next EXEC.
- start is ignored while busy=1. It is level-sampled, so holding it high re-triggers on the first IDLE cycle after DONE.
- Operand or opcode changes after CAPTURE do not affect the operation in flight.

## Timing
- Reset (asynchronous, any state): state=IDLE, result=0, ovf=0, done=0, busy=0, all latched registers=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Latency: start sampled high at edge n. CAPTURE during cycle n+1, EXEC during n+2. result/ovf valid and done=1 during cycle n+3. IDLE at n+4.
- Throughput: one operation per 4 cycles with start held high.
- busy is high from cycle n+1 through n+3 inclusive.
- adder_sum is sampled in the same cycle the operands are driven. The adder is purely combinational and must settle within one CLOCK_50 period.

## Configuration
- CALC_CHAIN_EN defined:
  - Add input chain (1 bit).
  - When chain=1 is sampled together with start in IDLE, CAPTURE loads ra from the current result register instead of a_in. rb and op still come from b_in and op.
  - This supports accumulation, e.g. repeated add.
  - chain is ignored outside IDLE.
  - After reset the chained operand is 0.
- CALC_CHAIN_EN not defined:
  - No chain port.
  - ra always loads from a_in.

## Test plan
- Reset: assert RESET_N=0 mid-EXEC → immediately result=0, ovf=0, busy=0, done=0. After release, state is IDLE and no done pulse occurs.
- Add: a=0011, b=0100, op=000, start pulse → done exactly 3 cycles after the start edge, result=0111, ovf=0. a=0111, b=0001 → result=1000, ovf=1.
- Subtract:
  - op=001, a=0010, b=0101 → result=1101 (−3), ovf=0.
  - op=101, same operands → result=0011.
  - op=001, a=1000, b=0001 → result=0111, ovf=1.
- Absolute value:
  - op=110, a=1011 → result=0101, ovf=0.
  - op=010, b=0110 → result=0110.
  - op=111, a=1000 → result=1000, ovf=1.
- Busy/capture: start held high while a_in changes in EXEC → in-flight result uses the captured value. A second operation begins on the IDLE cycle after DONE; busy shows a one-cycle low gap.
- CALC_CHAIN_EN: a=0001, b=0010, op=000 → result=0011. Then chain=1, b=0010 → result=0101. Then chain=1, b=0011 → result=1000, ovf=1.
